// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_W         = 16;
    localparam int         CSUM_W        = 8;

    // Byte address of a word: base plus zero-extended 4*index, 32-bit wrap.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [LEN_W-1:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs bytes LSB-first into a 32-bit word and pulses word_valid_o the cycle
// after the fourth byte of each word is shifted in.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [31:0] sr_q;
    logic        wv_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
            sr_q  <= 32'd0;
            wv_q  <= 1'b0;
        end else if (clear_i) begin
            idx_q <= 2'd0;
            sr_q  <= 32'd0;
            wv_q  <= 1'b0;
        end else begin
            wv_q <= shift_i && (idx_q == 2'd3);
            if (shift_i) begin
                sr_q  <= {byte_i, sr_q[31:8]};
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_o       = sr_q;
    assign word_valid_o = wv_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Frame-driven instruction memory loader: parses SYNC/LEN/DATA/CSUM bytes,
// writes packed words to instruction memory, then releases the core.
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic [31:0]       instr_addr,
    output logic [31:0]       instr_data,
    output logic              instr_we,
    output logic              start,
    output logic              load_done,
    output logic              load_err,
    output logic [LEN_W-1:0]  word_cnt
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CSUM_W-1:0]   sum_q, sum_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;

    logic                accept, frame_start, shift;
    logic                word_valid;
    logic [1:0]          byte_idx;
    logic [31:0]         word;
    logic [LEN_W-1:0]    n_full;
    logic [CSUM_W-1:0]   sum_next;

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (reload | frame_start),
        .shift_i      (shift),
        .byte_i       (rx_data),
        .byte_idx_o   (byte_idx),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Stalling input during the strobe keeps writes and byte accepts disjoint.
    assign rx_ready = (state_q inside {IDLE, LEN0, LEN1, DATA, CSUM}) && !word_valid;
    assign accept   = rx_valid && rx_ready;
    assign instr_we = word_valid && !reload;
    assign n_full   = {rx_data, len_q[7:0]};
    assign sum_next = sum_q + rx_data;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        word_cnt_d  = word_cnt_q;
        frame_start = 1'b0;
        shift       = 1'b0;

        if (instr_we) word_cnt_d = word_cnt_q + 16'd1;

        if (accept) begin
            unique case (state_q)
                IDLE: if (rx_data == SYNC_BYTE) begin
                    state_d     = LEN0;
                    sum_d       = '0;
                    word_cnt_d  = '0;
                    frame_start = 1'b1;
                end
                LEN0: begin
                    len_d[7:0] = rx_data;
                    sum_d      = sum_next;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d[15:8] = rx_data;
                    sum_d       = sum_next;
                    if ({16'd0, n_full} > 32'(IMEM_DEPTH)) state_d = ERR;
                    else if (n_full == '0)                 state_d = CSUM;
                    else                                   state_d = DATA;
                end
                DATA: begin
                    shift = 1'b1;
                    sum_d = sum_next;
                    // Earlier words have already been counted by their strobes.
                    if (byte_idx == 2'd3 && (word_cnt_q + 16'd1) == len_q)
                        state_d = CSUM;
                end
                CSUM: begin
                    sum_d   = sum_next;
                    state_d = (sum_next == '0) ? RUN : ERR;
                end
                default: ;
            endcase
        end

        if (reload) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign instr_addr = word_addr(BASE_ADDR, word_cnt_q);
    assign instr_data = word;
    assign start      = (state_q == RUN);
    assign load_done  = (state_q == RUN);
    assign load_err   = (state_q == ERR);
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed frames with a write scoreboard drained by an independent monitor.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        reload = 1'b0;
    logic [31:0] instr_addr, instr_data;
    logic        instr_we, start, load_done, load_err;
    logic [15:0] word_cnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;

    imem_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .instr_we   (instr_we),
        .start      (start),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    // Sends tx_q, holding each byte until accepted, with 'gap' idle cycles after.
    task automatic send_all(input int gap);
        int n;
        foreach (tx_q[i]) begin
            @(negedge clk);
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            n = 0;
            while (!rx_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n == 50) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: got 0 expected 1 (byte %h)", tx_q[i]);
            end
            @(posedge clk);
            #1 rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && instr_we) begin
                check("rx_ready_in_strobe", {31'd0, rx_ready}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             instr_addr, instr_data);
                end else begin
                    w = sb.pop_front();
                    check("wr_addr", instr_addr, w.addr);
                    check("wr_data", instr_data, w.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        check("rst_start",     {31'd0, start},     32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err",  {31'd0, load_err},  32'd0);
        check("rst_instr_we",  {31'd0, instr_we},  32'd0);
        check("rst_addr",      instr_addr,         32'd0);
        check("rst_data",      instr_data,         32'd0);
        check("rst_word_cnt",  {16'd0, word_cnt},  32'd0);
        rst = 1'b0;

        // Two-word frame, sum 0x08, checksum 0xF8.
        expect_wr(32'h0, 32'h0050_0013);
        expect_wr(32'h4, 32'h0010_0093);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hF8};
        send_all(0);
        check("a_start",     {31'd0, start},     32'd1);
        check("a_load_done", {31'd0, load_done}, 32'd1);
        check("a_load_err",  {31'd0, load_err},  32'd0);
        check("a_rx_ready",  {31'd0, rx_ready},  32'd0);
        check("a_word_cnt",  {16'd0, word_cnt},  32'd2);
        check("a_sb_empty",  sb.size(),          32'd0);
        pulse_reload();
        check("reload_start",    {31'd0, start},    32'd0);
        check("reload_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Same frame, bad checksum: writes still occur, then error.
        expect_wr(32'h0, 32'h0050_0013);
        expect_wr(32'h4, 32'h0010_0093);
        tx_q[11] = 8'hF9;
        send_all(0);
        check("b_load_err",  {31'd0, load_err},  32'd1);
        check("b_start",     {31'd0, start},     32'd0);
        check("b_load_done", {31'd0, load_done}, 32'd0);
        check("b_rx_ready",  {31'd0, rx_ready},  32'd0);
        check("b_word_cnt",  {16'd0, word_cnt},  32'd2);
        check("b_sb_empty",  sb.size(),          32'd0);
        pulse_reload();
        check("b_reload_err", {31'd0, load_err}, 32'd0);

        // N = 1025 exceeds depth: error right after LEN_HI, no writes.
        tx_q = '{8'hA5, 8'h01, 8'h04};
        send_all(0);
        check("c_load_err", {31'd0, load_err}, 32'd1);
        check("c_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("c_still_err", {31'd0, load_err}, 32'd1);
        pulse_reload();

        // Garbage before sync, empty frame.
        tx_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_all(0);
        check("d_start",    {31'd0, start},    32'd1);
        check("d_word_cnt", {16'd0, word_cnt}, 32'd0);
        pulse_reload();

        // One-word frame with idle cycles between bytes; sum 0x64, csum 0x9C.
        expect_wr(32'h0, 32'h0050_0013);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h9C};
        send_all(1);
        check("e_start",    {31'd0, start},    32'd1);
        check("e_word_cnt", {16'd0, word_cnt}, 32'd1);
        check("e_sb_empty", sb.size(),         32'd0);
        pulse_reload();

        // Abandon a frame mid-word, then load a clean one; sum 0xA4, csum 0x5C.
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_all(0);
        pulse_reload();
        check("f_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("f_load_err", {31'd0, load_err}, 32'd0);
        expect_wr(32'h0, 32'h0010_0093);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h5C};
        send_all(0);
        check("f_start",     {31'd0, start},     32'd1);
        check("f_load_done", {31'd0, load_done}, 32'd1);
        check("f_word_cnt",  {16'd0, word_cnt},  32'd1);
        check("f_sb_empty",  sb.size(),          32'd0);

        // Asynchronous reset while running.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("g_start",     {31'd0, start},     32'd0);
        check("g_load_done", {31'd0, load_done}, 32'd0);
        check("g_rx_ready",  {31'd0, rx_ready},  32'd1);
        check("g_word_cnt",  {16'd0, word_cnt},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
